// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths, MD latencies and encodings for the D-stage hazard scoreboard.
package hazard_scoreboard_pkg;

   localparam int TW       = 2;
   localparam int RAW      = 5;
   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;

   localparam logic [TW-1:0] TUSE_NONE = '1;

   localparam int FWD_RF = 0;

   function automatic int md_cnt_width(input int mult_cyc, input int div_cyc);
      return $clog2(((mult_cyc > div_cyc) ? mult_cyc : div_cyc) + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage request (operands, producer, MD class) and hazard response bundle.
interface hazard_scoreboard_if #(
   parameter int TW   = 2,
   parameter int RAW  = 5,
   parameter int SELW = 2
);
   logic           clr;
   logic [RAW-1:0] d_rs;
   logic [RAW-1:0] d_rt;
   logic [TW-1:0]  d_tuse_rs;
   logic [TW-1:0]  d_tuse_rt;
   logic [RAW-1:0] d_dst;
   logic           d_wen;
   logic [TW-1:0]  d_tnew;
   logic           d_md_start;
   logic           d_md_div;
   logic           d_md_use;
   logic           stall;
   logic [SELW-1:0] fwd_sel_rs;
   logic [SELW-1:0] fwd_sel_rt;
   logic           md_busy;

   modport master (
      output clr, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_wen, d_tnew,
             d_md_start, d_md_div, d_md_use,
      input  stall, fwd_sel_rs, fwd_sel_rt, md_busy
   );

   modport slave (
      input  clr, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_wen, d_tnew,
             d_md_start, d_md_div, d_md_use,
      output stall, fwd_sel_rs, fwd_sel_rt, md_busy
   );
endinterface

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Multiply/divide busy countdown: loads on an accepted MD start, busy while nonzero.
// Busy rises the edge after the load; async reset clears it immediately.
module md_busy_counter
   import hazard_scoreboard_pkg::*;
#(
   parameter int MULT_CYC = hazard_scoreboard_pkg::MULT_CYC,
   parameter int DIV_CYC  = hazard_scoreboard_pkg::DIV_CYC
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load_i,
   input  logic div_i,
   output logic busy_o
);
   localparam int CW = md_cnt_width(MULT_CYC, DIV_CYC);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = div_i ? CW'(DIV_CYC) : CW'(MULT_CYC);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller for D: NSTAGE-deep producer shift chain plus MD busy counter.
// Outputs are combinational from state and D inputs; a stall turns entry 0 into a bubble.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NSTAGE   = 3,
   parameter int TW       = hazard_scoreboard_pkg::TW,
   parameter int RAW      = hazard_scoreboard_pkg::RAW,
   parameter int MULT_CYC = hazard_scoreboard_pkg::MULT_CYC,
   parameter int DIV_CYC  = hazard_scoreboard_pkg::DIV_CYC
) (
   input  logic          clk,
   input  logic          reset_n,
   hazard_scoreboard_if.slave sb
);
   localparam int SELW = $clog2(NSTAGE + 1);
   localparam logic [TW-1:0] TUSE_OFF = '1;

   logic [NSTAGE-1:0]          vld_q, vld_d;
   logic [NSTAGE-1:0][RAW-1:0] dst_q, dst_d;
   logic [NSTAGE-1:0][TW-1:0]  tnew_q, tnew_d;
   logic [NSTAGE-1:0]          hit_rs, hit_rt;

   logic            stall;
   logic            md_busy;
   logic            fnd_rs, fnd_rt;
   logic [TW-1:0]   tn_rs, tn_rt;
   logic [SELW-1:0] idx_rs, idx_rt;
   logic            stall_rs, stall_rt;

   // Entry 0 receives the D instruction; older entries age by one stage with saturating tnew.
   for (genvar g = 0; g < NSTAGE; g++) begin : g_chain
      if (g == 0) begin : g_head
         assign vld_d[g]  = !sb.clr && sb.d_wen && (sb.d_dst != '0) && !stall;
         assign dst_d[g]  = sb.d_dst;
         assign tnew_d[g] = sb.d_tnew;
      end else begin : g_body
         assign vld_d[g]  = !sb.clr && vld_q[g-1];
         assign dst_d[g]  = dst_q[g-1];
         assign tnew_d[g] = (tnew_q[g-1] == '0) ? '0 : tnew_q[g-1] - 1'b1;
      end
      assign hit_rs[g] = vld_q[g] && (dst_q[g] == sb.d_rs) && (sb.d_rs != '0);
      assign hit_rt[g] = vld_q[g] && (dst_q[g] == sb.d_rt) && (sb.d_rt != '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q  <= '0;
         dst_q  <= '0;
         tnew_q <= '0;
      end else begin
         vld_q  <= vld_d;
         dst_q  <= dst_d;
         tnew_q <= tnew_d;
      end
   end

   // Scan oldest to youngest so the youngest matching producer overrides older ones.
   always_comb begin
      fnd_rs = 1'b0;
      fnd_rt = 1'b0;
      tn_rs  = '0;
      tn_rt  = '0;
      idx_rs = SELW'(FWD_RF);
      idx_rt = SELW'(FWD_RF);
      for (int i = NSTAGE - 1; i >= 0; i--) begin
         if (hit_rs[i]) begin
            fnd_rs = 1'b1;
            tn_rs  = tnew_q[i];
            idx_rs = SELW'(i + 1);
         end
         if (hit_rt[i]) begin
            fnd_rt = 1'b1;
            tn_rt  = tnew_q[i];
            idx_rt = SELW'(i + 1);
         end
      end
   end

   assign stall_rs = fnd_rs && (sb.d_tuse_rs != TUSE_OFF) && (tn_rs > sb.d_tuse_rs);
   assign stall_rt = fnd_rt && (sb.d_tuse_rt != TUSE_OFF) && (tn_rt > sb.d_tuse_rt);
   assign stall    = stall_rs || stall_rt || (sb.d_md_use && md_busy);

   assign sb.stall      = stall;
   assign sb.md_busy    = md_busy;
   assign sb.fwd_sel_rs = (fnd_rs && tn_rs == '0) ? idx_rs : SELW'(FWD_RF);
   assign sb.fwd_sel_rt = (fnd_rt && tn_rt == '0) ? idx_rt : SELW'(FWD_RF);

   md_busy_counter #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (sb.d_md_start && !stall),
      .div_i   (sb.d_md_div),
      .busy_o  (md_busy)
   );
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised stall/forward controller for the MIPS pipeline.
- Consumes per-instruction Tuse/Tnew, register-address and MD-class information for the instruction in D.
- Tracks in-flight producers in an NSTAGE-deep scoreboard shift register, and tracks the multiply/divide unit busy time with a countdown counter.
- Drives the D-stage stall, D-stage forward selects and md_busy.

Parameters:
- NSTAGE, 3, number of downstream stages holding producers (entry 0 = E, 1 = M, 2 = W).
- TW, 2, width of Tnew/Tuse fields; all-ones Tuse means "operand unused".
- RAW, 5, register address width.
- MULT_CYC, 5, busy cycles for mult/multu.
- DIV_CYC, 10, busy cycles for div/divu.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous scoreboard flush (all entries invalid).
- d_rs  in  RAW  rs address of the D instruction.
- d_rt  in  RAW  rt address of the D instruction.
- d_tuse_rs  in  TW  Tuse for rs.
- d_tuse_rt  in  TW  Tuse for rt.
- d_dst  in  RAW  destination register.
- d_wen  in  1  D instruction writes d_dst.
- d_tnew  in  TW  Tnew at E entry.
- d_md_start  in  1  D instruction is mult/multu/div/divu.
- d_md_div  in  1  with d_md_start: 1 = div class, 0 = mult class.
- d_md_use  in  1  D instruction is mfhi/mflo/mthi/mtlo or md class.
- stall  out  1  freeze PC and the F/D register; insert a bubble into E.
- fwd_sel_rs  out  clog2(NSTAGE+1)  0 = regfile; k = entry k-1.
- fwd_sel_rt  out  clog2(NSTAGE+1)  same encoding for rt.
- md_busy  out  1  MD counter nonzero.

Behaviour:
- Entry state: valid, dst[RAW], tnew[TW]. Entry i models stage i after D.
- Reset (async, reset_n=0): all entries invalid, tnew 0, MD counter 0. Outputs are combinational from state and inputs; with reset asserted and no D instruction active they read stall=0, fwd_sel_*=0, md_busy=0. Reset asserted mid-divide clears the counter immediately.
- Shift, every clock:
  - entry[i] <= entry[i-1] for i≥1, with tnew decremented and saturating at 0.
  - entry[0] <= {d_wen && d_dst!=0 && !stall, d_dst, d_tnew}.
  - A stall therefore inserts an invalid bubble into entry 0 while older entries keep advancing.
- clr: synchronous, takes priority over the shift; every entry goes invalid. clr does not affect the MD counter.
- Match for rs: entry valid, dst==d_rs, d_rs!=0. The youngest (lowest-index) match wins; older matches are ignored.
- Stall, rs side: d_tuse_rs != all-ones and youngest-match tnew > d_tuse_rs. The rt side is symmetric.
- MD stall: d_md_use && md_busy.
- stall = rs stall | rt stall | MD stall.
- Forward selects: fwd_sel_rs = k+1 when the youngest rs match is entry k with tnew==0, else 0. Same rule for rt.
  - A matching tnew>0 that does not stall gives 0; the E-stage forward mux resolves it later.
  - fwd_sel is a don't-care while stall=1.
- MD counter:
  - On an edge with d_md_start && !stall, load DIV_CYC if d_md_div else MULT_CYC.
  - Otherwise decrement while nonzero.
  - md_busy = (counter != 0).
  - A new start while busy cannot occur, because d_md_use already stalls it.
- $0: never a valid producer and never matches; writes to $0 never stall.
- Simultaneous events:
  - clr and stall in the same cycle: clr wins for the scoreboard.
  - MD load and reset: reset wins.
- Width: all tnew arithmetic is TW-bit saturating with no wrap. MULT_CYC and DIV_CYC must fit the counter width, clog2(max(MULT_CYC, DIV_CYC)+1).

Decomposition:
- Shared package holds:
  - TW, RAW;
  - the TUSE_NONE constant (all-ones);
  - the MULT_CYC/DIV_CYC defaults;
  - the forward-select encoding constants (FWD_RF=0).
- One natural sub-module: md_busy_counter (load/decrement/busy) instantiated once.
- The scoreboard shift chain and the match logic stay inline via generate loops.

Test Plan:
- lw $1 (tnew 2) then addu $2,$1,$0 (Tuse 1,1) -> stall=1 for exactly 1 cycle, then stall=0, fwd_sel_rs=0.
- addu $3 (tnew 1) then beq $3,$3 (Tuse 0,0) -> stall 1 cycle; next cycle fwd_sel_rs=fwd_sel_rt=2.
- jal (dst $31, tnew 0) then jr $31 (Tuse 0) -> no stall, fwd_sel_rs=1.
- mult then mflo -> md_busy high for 5 cycles, stall 5 cycles, mflo issues on cycle 6. Repeat with div -> 10 stall cycles.
- ori $0 (tnew 1) then beq $0,$0 -> no stall, fwd_sel=0. Two producers of $5 in entries 0 and 1 -> entry 0 decides.
- div issued, then reset_n low for 1 cycle during busy -> md_busy=0 asynchronously, all entries invalid, no stall afterwards. clr pulse with lw $1 in entry 0 -> following consumer of $1 sees no stall.
